uart_bus_bridge: RTL and testbench

UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

---
 rtl/uart_bus_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// UART-to-bus bridge.
// Receives command frames over an 8N1 UART, issues a single 32-bit bus
// access per frame, and sends the response back over the UART.
//
// Frame formats (bytes, in order):
//   write : 01 A0 A1 A2 A3 D0 D1 D2 D3  -> response AA
//   read  : 02 A0 A1 A2 A3              -> response R0 R1 R2 R3
//   other : any other first byte        -> response EE
// Multi-byte fields are little-endian.
//
// Ports:
//   clk_i, rst_ni    clock (rising edge), asynchronous active-low reset
//   uart_rx_i        serial input, idle high, asynchronous to clk_i
//   uart_tx_o        serial output, idle high
//   host_req_o       bus request, held until host_gnt_i is sampled
//   host_gnt_i       bus grant
//   host_addr_o      word-aligned byte address
//   host_we_o        write enable
//   host_be_o        byte enables, all ones while requesting
//   host_wdata_o     write data
//   host_rvalid_i    response valid (reads and writes)
//   host_rdata_i     read data, valid with host_rvalid_i
//   busy_o           parser outside CMD or a TX byte in flight
module uart_bus_bridge #(
    parameter int unsigned ClockFrequency     = 50_000_000,
    parameter int unsigned BaudRate           = 115_200,
    parameter int unsigned FrameTimeoutCycles = 500_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    output logic        busy_o
);

    localparam int unsigned ClocksPerBaud = ClockFrequency / BaudRate;
    localparam int unsigned HalfBaud      = (ClocksPerBaud / 2 > 0) ? ClocksPerBaud / 2 : 1;
    localparam int unsigned BaudW         = $clog2(ClocksPerBaud + 1);
    localparam int unsigned ToW           = $clog2(FrameTimeoutCycles + 1);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClocksPerBaud - 1);
    localparam logic [BaudW-1:0] HalfLast = BaudW'(HalfBaud - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(FrameTimeoutCycles - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {
        StCmd, StAddr, StWdata, StBusReq, StBusWait, StResp
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]       rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [BaudW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;

    tx_state_e        tx_state_q, tx_state_d;
    logic [BaudW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;

    state_e           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             is_write_q, is_write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      resp_buf_q, resp_buf_d;
    logic [2:0]       resp_left_q, resp_left_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;

    // ------------------------------------------------------------------
    // RX: synchroniser and 8N1 receiver
    // ------------------------------------------------------------------
    logic rx_bit;
    logic rx_fall;
    logic rx_valid;
    logic rx_err;

    // Flops 0 and 1 synchronise; flop 2 is the previous value for edge detection.
    assign rx_bit  = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        rx_err     = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // A high start sample is a glitch, not a frame.
                    rx_state_d = rx_bit ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BaudLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_bit, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                if (rx_cnt_q == BaudLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    rx_valid   = rx_bit;
                    rx_err     = ~rx_bit;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // TX: 8N1 transmitter, loaded by the parser
    // ------------------------------------------------------------------
    logic       tx_load;
    logic [7:0] tx_byte;
    logic       tx_stop_done;
    logic       tx_ready;

    assign tx_stop_done = (tx_state_q == TxStop) && (tx_cnt_q == BaudLast);
    // Loading on the last stop cycle gives back-to-back bytes with one stop bit.
    assign tx_ready     = (tx_state_q == TxIdle) || tx_stop_done;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TxIdle: tx_cnt_d = '0;
            TxStart: begin
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end
                end
            end
            TxStop: begin
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        if (tx_load) begin
            tx_state_d = TxStart;
            tx_cnt_d   = '0;
            tx_shift_d = tx_byte;
        end
    end

    always_comb begin
        unique case (tx_state_q)
            TxStart: uart_tx_o = 1'b0;
            TxData:  uart_tx_o = tx_shift_q[0];
            default: uart_tx_o = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parser and bus master
    // ------------------------------------------------------------------
    logic bus_done;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_buf_d  = resp_buf_q;
        resp_left_d = resp_left_q;
        to_cnt_d    = to_cnt_q;
        tx_load     = 1'b0;
        tx_byte     = resp_buf_q[7:0];
        bus_done    = 1'b0;
        unique case (state_q)
            StCmd: begin
                if (rx_valid) begin
                    if (rx_shift_q == 8'h01 || rx_shift_q == 8'h02) begin
                        is_write_d = (rx_shift_q == 8'h01);
                        byte_cnt_d = '0;
                        to_cnt_d   = '0;
                        state_d    = StAddr;
                    end else begin
                        resp_buf_d  = 32'h0000_00EE;
                        resp_left_d = 3'd1;
                        state_d     = StResp;
                    end
                end
            end
            StAddr, StWdata: begin
                if (rx_err) begin
                    state_d = StCmd;
                end else if (rx_valid) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (state_q == StAddr) begin
                        addr_d = {rx_shift_q, addr_q[31:8]};
                    end else begin
                        wdata_d = {rx_shift_q, wdata_q[31:8]};
                    end
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == StAddr && is_write_q) begin
                            state_d = StWdata;
                        end else begin
                            state_d = StBusReq;
                        end
                    end
                end else if (to_cnt_q == ToLast) begin
                    state_d = StCmd;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StBusReq: begin
                if (host_gnt_i) begin
                    state_d  = StBusWait;
                    bus_done = host_rvalid_i;
                end
            end
            StBusWait: bus_done = host_rvalid_i;
            StResp: begin
                if (resp_left_q != 3'd0) begin
                    if (tx_ready) begin
                        tx_load     = 1'b1;
                        resp_buf_d  = {8'h00, resp_buf_q[31:8]};
                        resp_left_d = resp_left_q - 1'b1;
                    end
                end else if (tx_stop_done) begin
                    state_d = StCmd;
                end
            end
            default: state_d = StCmd;
        endcase
        if (bus_done) begin
            state_d = StResp;
            if (is_write_q) begin
                resp_buf_d  = 32'h0000_00AA;
                resp_left_d = 3'd1;
            end else begin
                resp_buf_d  = host_rdata_i;
                resp_left_d = 3'd4;
            end
        end
    end

    assign host_req_o   = (state_q == StBusReq);
    assign host_addr_o  = addr_q & 32'hFFFF_FFFC;
    assign host_we_o    = is_write_q;
    assign host_be_o    = {4{host_req_o}};
    assign host_wdata_o = wdata_q;
    assign busy_o       = (state_q != StCmd) || (tx_state_q != TxIdle);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_q   <= 3'b111;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            state_q     <= StCmd;
            byte_cnt_q  <= '0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_buf_q  <= '0;
            resp_left_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            rx_sync_q   <= {rx_sync_q[1:0], uart_rx_i};
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_buf_q  <= resp_buf_d;
            resp_left_q <= resp_left_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: drives UART frames, models the
// bus responder, and checks requests and TX bytes against a scoreboard.
module tb_uart_bus_bridge;

    localparam int unsigned Cpb = 10;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic        uart_tx;
    logic        host_req;
    logic        host_gnt;
    logic [31:0] host_addr;
    logic        host_we;
    logic [3:0]  host_be;
    logic [31:0] host_wdata;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        busy;

    uart_bus_bridge #(
        .ClockFrequency    (1_000_000),
        .BaudRate          (100_000),
        .FrameTimeoutCycles(2000)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .uart_rx_i    (uart_rx),
        .uart_tx_o    (uart_tx),
        .host_req_o   (host_req),
        .host_gnt_i   (host_gnt),
        .host_addr_o  (host_addr),
        .host_we_o    (host_we),
        .host_be_o    (host_be),
        .host_wdata_o (host_wdata),
        .host_rvalid_i(host_rvalid),
        .host_rdata_i (host_rdata),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    req_t       exp_req[$];
    logic [7:0] exp_tx[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Responder configuration; gnt_delay < 0 means never grant.
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    logic [31:0] rdata_val = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (Cpb) @(negedge clk);
        end
        uart_rx = stop;
        repeat (Cpb) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    // Byte i of the frame is data[8*i +: 8]; byte 0 goes first.
    task automatic send_frame(input logic [71:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(data[8*i +: 8], 1'b1);
        end
    endtask

    task automatic push_read(input logic [31:0] addr, input logic [31:0] rdata);
        req_t r;
        r.addr  = addr;
        r.we    = 1'b0;
        r.wdata = '0;
        exp_req.push_back(r);
        rdata_val = rdata;
        for (int i = 0; i < 4; i++) begin
            exp_tx.push_back(rdata[8*i +: 8]);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_req.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 5000), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    // Bus responder and request checker.
    initial begin
        req_t        e;
        logic [31:0] a0;
        host_gnt    = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && host_req) begin
                check("req_expected", 32'(exp_req.size() > 0), 32'd1);
                if (exp_req.size() > 0) begin
                    e = exp_req.pop_front();
                    check("req_addr", host_addr, e.addr);
                    check("req_we", 32'(host_we), 32'(e.we));
                    check("req_be", 32'(host_be), 32'hF);
                    if (e.we) check("req_wdata", host_wdata, e.wdata);
                end
                a0 = host_addr;
                if (gnt_delay < 0) begin
                    wait (!rst_n);
                end else begin
                    repeat (gnt_delay) @(negedge clk);
                    check("req_hold", 32'(host_req), 32'd1);
                    check("addr_hold", host_addr, a0);
                    host_gnt   = 1'b1;
                    host_rdata = rdata_val;
                    if (rv_delay == 0) host_rvalid = 1'b1;
                    @(negedge clk);
                    host_gnt    = 1'b0;
                    host_rvalid = 1'b0;
                    check("req_drop", 32'(host_req), 32'd0);
                    if (rv_delay > 0) begin
                        repeat (rv_delay - 1) @(negedge clk);
                        host_rvalid = 1'b1;
                        @(negedge clk);
                        host_rvalid = 1'b0;
                    end
                end
            end
        end
    end

    // TX decoder: samples mid-bit, checks back-to-back spacing.
    initial begin
        logic [7:0] d;
        int         last_start;
        logic       have_last;
        have_last = 1'b0;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (rst_n && !uart_tx) begin
                if (have_last && (cyc - last_start) < 150) begin
                    check("tx_gap", 32'(cyc - last_start), 32'd100);
                end
                last_start = cyc;
                have_last  = 1'b1;
                repeat (4) @(negedge clk);
                check("tx_start", 32'(uart_tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (Cpb) @(negedge clk);
                    d[i] = uart_tx;
                end
                repeat (Cpb) @(negedge clk);
                check("tx_stop", 32'(uart_tx), 32'd1);
                check("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
                if (exp_tx.size() > 0) check("tx_byte", 32'(d), 32'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_t r;
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_req", 32'(host_req), 32'd0);
        check("rst_addr", host_addr, 32'd0);
        check("rst_we", 32'(host_we), 32'd0);
        check("rst_be", 32'(host_be), 32'd0);
        check("rst_wdata", host_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write, grant after 3 cycles, response 2 later.
        gnt_delay = 3;
        rv_delay  = 2;
        r.addr  = 32'h7654_3210;
        r.we    = 1'b1;
        r.wdata = 32'hDEAD_BEEF;
        exp_req.push_back(r);
        exp_tx.push_back(8'hAA);
        send_frame(72'hDE_AD_BE_EF_76_54_32_10_01, 9);
        wait_drain("write");

        // Read with grant and rvalid in the same cycle.
        gnt_delay = 0;
        rv_delay  = 0;
        push_read(32'h0000_0004, 32'h1234_5678);
        send_frame(72'h00_00_00_00_00_00_00_04_02, 5);
        wait_drain("read_same");

        // Unknown command, then a normal read.
        exp_tx.push_back(8'hEE);
        send_byte(8'h7F, 1'b1);
        wait_drain("bad_cmd");
        gnt_delay = 1;
        rv_delay  = 1;
        push_read(32'h0000_000C, 32'hCAFE_F00D);
        send_frame(72'h00_00_00_00_00_00_00_0C_02, 5);
        wait_drain("read_after_bad");

        // Inter-byte timeout abandons the write.
        send_frame(72'h00_00_00_00_00_00_00_00_01, 3);
        repeat (2500) @(negedge clk);
        check("timeout_busy", 32'(busy), 32'd0);
        gnt_delay = 2;
        rv_delay  = 3;
        push_read(32'h0000_0008, 32'h0000_0055);
        send_frame(72'h00_00_00_00_00_00_00_08_02, 5);
        wait_drain("read_after_timeout");

        // Framing error inside ADDR aborts silently.
        send_byte(8'h01, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (60) @(negedge clk);
        check("ferr_busy", 32'(busy), 32'd0);
        check("ferr_tx", 32'(uart_tx), 32'd1);
        gnt_delay = 0;
        rv_delay  = 4;
        push_read(32'h0000_0010, 32'hA5A5_5A5A);
        send_frame(72'h00_00_00_00_00_00_00_10_02, 5);
        wait_drain("read_after_ferr");

        // Reset while a request is pending.
        gnt_delay = -1;
        r.addr  = 32'h0000_0020;
        r.we    = 1'b0;
        r.wdata = '0;
        exp_req.push_back(r);
        send_frame(72'h00_00_00_00_00_00_00_20_02, 5);
        begin
            int n;
            n = 0;
            while (!host_req && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("rst_req_seen", 32'(host_req), 32'd1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(host_req), 32'd0);
        check("midrst_tx", 32'(uart_tx), 32'd1);
        check("midrst_be", 32'(host_be), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        gnt_delay = 2;
        rv_delay  = 1;
        push_read(32'h0000_0024, 32'h8765_4321);
        send_frame(72'h00_00_00_00_00_00_00_24_02, 5);
        wait_drain("read_after_rst");

        check("req_left", 32'(exp_req.size()), 32'd0);
        check("tx_left", 32'(exp_tx.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
